sa_result_writer: RTL and testbench
===================================

// Module: sa_result_writer
// PURPOSE
//  Write-back end of the 2x2 systolic datapath. The weight preloader and feature loader read operands from memory.
//  This block takes the four result registers (c11,c12,c21,c22) after a feature pass completes.
//  It stores them as a 2x2 tile into the output memory at a caller-supplied base address.
//  It sits between the systolic top and the output SRAM write port and is sequenced by the same controller that drives Feature_Loader_en.
// PARAMETERS
//  DATA_W      8   width of each result word and of mem_wdata
//  ADDR_W      6   memory address width; addresses wrap modulo 2**ADDR_W
//  ROW_STRIDE  4   address distance between tile row 0 and tile row 1
// PORTS
//  clk          in   1       single clock, all logic on rising edge
//  rst          in   1       synchronous, active-low reset (0 = reset)
//  start        in   1       request to store one tile; sampled only in IDLE
//  out_baseaddr in   ADDR_W  tile base address, captured with start
//  c11,c12      in   DATA_W  result row 0, captured with start
//  c21,c22      in   DATA_W  result row 1, captured with start
//  mem_ready    in   1       memory accepts the write presented this cycle
//  mem_we       out  1       write strobe
//  mem_addr     out  ADDR_W  write address
//  mem_wdata    out  DATA_W  write data
//  busy         out  1       1 while a tile is being stored (WRITE or DONE)
//  is_WB_done_o out  1       one-cycle pulse after the 4th write is accepted
// BEHAVIOUR
//  Reset (rst==0 at a clock edge): state=IDLE, idx=0, captured regs cleared.
//   mem_we=0, mem_addr=0, mem_wdata=0, busy=0, is_WB_done_o=0.
//   A reset during WRITE aborts the tile; no further writes are issued.
//  FSM states: IDLE -> WRITE -> DONE -> IDLE.
//   IDLE:  if start=1, capture c11..c22 and out_baseaddr, set idx=0, go to WRITE. Otherwise stay in IDLE.
//   WRITE: mem_we=1. Address and data are registered outputs from idx:
//      idx0: addr=base,              data=c11
//      idx1: addr=base+1,            data=c12
//      idx2: addr=base+ROW_STRIDE,   data=c21
//      idx3: addr=base+ROW_STRIDE+1, data=c22
//     Additions are truncated to ADDR_W bits, which gives the wrap-around.
//     mem_ready=1 at an edge: the word is accepted and idx advances. After idx3 is accepted, go to DONE.
//     mem_ready=0: hold mem_we, mem_addr and mem_wdata stable. Stall length is unbounded.
//   DONE:  mem_we=0, is_WB_done_o=1 for exactly one cycle, then go to IDLE.
//  Latency: the first write appears the cycle after start is sampled.
//   With mem_ready tied high, the pattern is: 4 write cycles, then the done pulse on cycle 5, then IDLE on cycle 6.
//   Earliest next start is sampled on cycle 6.
//  start in WRITE/DONE is ignored (not queued).
//   The controller must wait for is_WB_done_o; a start held high is re-sampled in IDLE.
//  Input changes on c11..c22 and out_baseaddr after capture have no effect on the tile in flight.
//  busy=1 exactly in WRITE and DONE.
//  mem_addr and mem_wdata hold their last values when mem_we=0. They are 0 only after reset.
// TESTING
//  1 Reset: hold rst=0 for 3 cycles with start=1 -> all outputs 0, no mem_we.
//  2 Basic tile: mem_ready=1, base=6'h09, c=(11,12,21,22), start 1 cycle
//     -> writes (09,11),(0A,12),(0D,21),(0E,22) on consecutive cycles.
//     -> is_WB_done_o pulses the next cycle; busy returns to 0 after the pulse.
//  3 Backpressure: same as 2 with mem_ready low for 3 cycles during idx1
//     -> (0A,12) held stable for 4 cycles, exactly 4 writes total, done after (0E,22).
//  4 Wrap: base=6'h3F -> addresses 3F,00,03,04.
//  5 Ignored start and input isolation: pulse start and change c11..c22 mid-tile
//     -> current tile data unchanged, no second tile until start is sampled in IDLE.
//  6 Reset mid-tile: assert rst=0 after the 2nd write -> outputs 0 next cycle, no 3rd/4th write.
//     -> a new start after release writes a full fresh tile.

Source files
------------

// File: rtl/sa_result_writer_if.sv
// rtl/sa_result_writer_if.sv - output SRAM write-port bundle for the result writer
//
// Purpose: carries one word-wide write request from the result writer to the
//          output memory, with a ready back-pressure from the memory.
// Signals:
//    mem_we     write strobe (writer -> memory)
//    mem_addr   write address, ADDR_W bits (writer -> memory)
//    mem_wdata  write data, DATA_W bits (writer -> memory)
//    mem_ready  memory accepts the write presented this cycle (memory -> writer)
// Modports: master = result writer, slave = memory side.

interface sa_result_writer_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6
);
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;

   modport master (
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_ready
   );

   modport slave (
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_ready
   );
endinterface

// File: rtl/sa_result_writer.sv
// rtl/sa_result_writer.sv - stores the 2x2 systolic result tile into output memory
//
// Purpose: on start, captures c11..c22 and a base address, then issues four
//          back-pressured writes laying the tile out as two rows separated by
//          ROW_STRIDE, followed by a one-cycle completion pulse.
// Ports:
//    clk           clock, rising edge
//    rst           synchronous active-low reset
//    start         store request, only honoured in IDLE
//    out_baseaddr  tile base address, captured with start
//    c11,c12       result row 0, captured with start
//    c21,c22       result row 1, captured with start
//    mem           master side of the output SRAM write port
//    busy          high while a tile is being written or completing
//    is_WB_done_o  one-cycle pulse after the fourth write is accepted

module sa_result_writer #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 6,
   parameter int ROW_STRIDE = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDR_W-1:0]      out_baseaddr,
   input  logic [DATA_W-1:0]      c11,
   input  logic [DATA_W-1:0]      c12,
   input  logic [DATA_W-1:0]      c21,
   input  logic [DATA_W-1:0]      c22,
   sa_result_writer_if.master     mem,
   output logic                   busy,
   output logic                   is_WB_done_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t            state;
   logic [1:0]        idx;
   logic [ADDR_W-1:0] base_q;
   logic [DATA_W-1:0] c11_q, c12_q, c21_q, c22_q;

   // idx bit 1 selects the tile row, bit 0 the column; the sum is kept at
   // ADDR_W bits so tiles near the top of memory wrap to address 0.
   function automatic logic [ADDR_W-1:0] tile_addr(
      input logic [ADDR_W-1:0] b,
      input logic [1:0]        i
   );
      logic [ADDR_W-1:0] off;
      off = (i[1] ? ADDR_W'(ROW_STRIDE) : ADDR_W'(0)) + (i[0] ? ADDR_W'(1) : ADDR_W'(0));
      return b + off;
   endfunction

   function automatic logic [DATA_W-1:0] tile_data(
      input logic [1:0]        i,
      input logic [DATA_W-1:0] d11,
      input logic [DATA_W-1:0] d12,
      input logic [DATA_W-1:0] d21,
      input logic [DATA_W-1:0] d22
   );
      logic [DATA_W-1:0] d;
      case (i)
         2'd0:    d = d11;
         2'd1:    d = d12;
         2'd2:    d = d21;
         default: d = d22;
      endcase
      return d;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= ST_IDLE;
         idx           <= 2'd0;
         base_q        <= '0;
         c11_q         <= '0;
         c12_q         <= '0;
         c21_q         <= '0;
         c22_q         <= '0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
         busy          <= 1'b0;
         is_WB_done_o  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               is_WB_done_o <= 1'b0;
               if (start) begin
                  base_q        <= out_baseaddr;
                  c11_q         <= c11;
                  c12_q         <= c12;
                  c21_q         <= c21;
                  c22_q         <= c22;
                  idx           <= 2'd0;
                  // First word comes straight from the inputs so it is on the
                  // bus the cycle after start is sampled.
                  mem.mem_we    <= 1'b1;
                  mem.mem_addr  <= out_baseaddr;
                  mem.mem_wdata <= c11;
                  busy          <= 1'b1;
                  state         <= ST_WRITE;
               end
            end

            ST_WRITE: begin
               // Without mem_ready nothing is touched, so the request holds.
               if (mem.mem_ready) begin
                  if (idx == 2'd3) begin
                     mem.mem_we   <= 1'b0;
                     is_WB_done_o <= 1'b1;
                     state        <= ST_DONE;
                  end else begin
                     idx           <= idx + 2'd1;
                     mem.mem_addr  <= tile_addr(base_q, idx + 2'd1);
                     mem.mem_wdata <= tile_data(idx + 2'd1, c11_q, c12_q, c21_q, c22_q);
                  end
               end
            end

            ST_DONE: begin
               // Address and data keep the last written word.
               is_WB_done_o <= 1'b0;
               busy         <= 1'b0;
               state        <= ST_IDLE;
            end

            default: begin
               mem.mem_we   <= 1'b0;
               is_WB_done_o <= 1'b0;
               busy         <= 1'b0;
               state        <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sa_result_writer.sv
// tb/tb_sa_result_writer.sv - scoreboard bench for sa_result_writer

module tb_sa_result_writer;

   localparam int DATA_W     = 8;
   localparam int ADDR_W     = 6;
   localparam int ROW_STRIDE = 4;

   typedef struct {
      int  addr;
      int  data;
      bit  last;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] out_baseaddr = '0;
   logic [DATA_W-1:0] c11 = '0, c12 = '0, c21 = '0, c22 = '0;
   logic              busy;
   logic              is_WB_done_o;

   sa_result_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mif ();

   sa_result_writer #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROW_STRIDE(ROW_STRIDE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .out_baseaddr(out_baseaddr),
      .c11(c11),
      .c12(c12),
      .c21(c21),
      .c22(c22),
      .mem(mif.master),
      .busy(busy),
      .is_WB_done_o(is_WB_done_o)
   );

   always #5 clk = ~clk;

   int  total = 0;
   int  bad = 0;
   wr_t sb[$];
   bit  mon_en = 0;
   bit  done_exp = 0;
   int  dones_exp = 0;
   int  dones_seen = 0;
   int  ready_mode = 0;   // 0: always ready, 1: random, 2: driven by stimulus
   logic mem_ready_drv = 1'b1;

   assign mif.mem_ready = mem_ready_drv;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 0) mem_ready_drv = 1'b1;
         else if (ready_mode == 1) mem_ready_drv = ($urandom_range(0, 2) != 0);
      end
   end

   // Monitor: the memory's view of the write port.
   bit          prev_stall = 0;
   logic [ADDR_W-1:0] prev_addr;
   logic [DATA_W-1:0] prev_data;
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("busy", int'(busy), int'(mif.mem_we | is_WB_done_o));
            check("done_pulse", int'(is_WB_done_o), int'(done_exp));
            if (is_WB_done_o) dones_seen++;
            done_exp = 0;
            if (prev_stall) begin
               check("hold_addr", int'(mif.mem_addr), int'(prev_addr));
               check("hold_data", int'(mif.mem_wdata), int'(prev_data));
            end
            if (mif.mem_we && mif.mem_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_write", int'(mif.mem_addr), -1);
               end else begin
                  wr_t e;
                  e = sb.pop_front();
                  check("wr_addr", int'(mif.mem_addr), e.addr);
                  check("wr_data", int'(mif.mem_wdata), e.data);
                  if (e.last) done_exp = 1;
               end
            end
            prev_stall = mif.mem_we && !mif.mem_ready;
            prev_addr  = mif.mem_addr;
            prev_data  = mif.mem_wdata;
         end
      end
   end

   // Reference: row r, column k lands at base + r*ROW_STRIDE + k, mod memory size.
   task automatic expect_tile(input int base, input int d[4], input int nwords);
      for (int i = 0; i < nwords; i++) begin
         wr_t e;
         e.addr = (base + (i / 2) * ROW_STRIDE + (i % 2)) % (1 << ADDR_W);
         e.data = d[i];
         e.last = (i == 3);
         sb.push_back(e);
      end
      if (nwords == 4) dones_exp++;
   endtask

   task automatic start_tile(input int base, input int d[4]);
      @(posedge clk);
      #1;
      out_baseaddr = ADDR_W'(base);
      c11 = DATA_W'(d[0]);
      c12 = DATA_W'(d[1]);
      c21 = DATA_W'(d[2]);
      c22 = DATA_W'(d[3]);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while ((sb.size() != 0 || busy) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         check({name, "_timeout"}, sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic check_zero(input string name);
      check({name, "_we"}, int'(mif.mem_we), 0);
      check({name, "_addr"}, int'(mif.mem_addr), 0);
      check({name, "_data"}, int'(mif.mem_wdata), 0);
      check({name, "_busy"}, int'(busy), 0);
      check({name, "_done"}, int'(is_WB_done_o), 0);
   endtask

   initial begin
      int d[4];
      int d2[4];

      // 1: reset with start held high
      rst = 1'b0;
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0;
      mon_en = 1;
      @(negedge clk);
      check_zero("reset");
      rst = 1'b1;

      // 2: basic tile
      d = '{8'h11, 8'h12, 8'h21, 8'h22};
      expect_tile(6'h09, d, 4);
      start_tile(6'h09, d);
      wait_idle("basic");
      check("basic_idle_busy", int'(busy), 0);

      // 3: backpressure during idx1
      ready_mode = 2;
      mem_ready_drv = 1'b1;
      expect_tile(6'h09, d, 4);
      start_tile(6'h09, d);      // returns in the idx0 cycle
      @(posedge clk);
      #1;
      mem_ready_drv = 1'b0;      // idx1 presented, stalled for 3 cycles
      repeat (3) @(posedge clk);
      #1;
      mem_ready_drv = 1'b1;
      wait_idle("bp");
      ready_mode = 0;

      // 4: wrap-around
      d = '{8'hA1, 8'hA2, 8'hB1, 8'hB2};
      expect_tile(6'h3F, d, 4);
      start_tile(6'h3F, d);
      wait_idle("wrap");

      // 5: start and input changes mid-tile are ignored
      d  = '{8'h31, 8'h32, 8'h41, 8'h42};
      d2 = '{8'hEE, 8'hDD, 8'hCC, 8'hBB};
      expect_tile(6'h10, d, 4);
      start_tile(6'h10, d);
      start_tile(6'h20, d2);
      repeat (6) @(negedge clk);
      check("iso_sb_empty", sb.size(), 0);
      check("iso_busy", int'(busy), 0);

      // 6: reset after the 2nd write
      d = '{8'h51, 8'h52, 8'h61, 8'h62};
      expect_tile(6'h04, d, 2);
      start_tile(6'h04, d);      // returns in the idx0 cycle
      @(posedge clk);
      #1;
      rst = 1'b0;                // idx1 cycle; reset takes effect at its end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check_zero("midrst");
      repeat (4) @(negedge clk);
      check("midrst_sb_empty", sb.size(), 0);
      d = '{8'h71, 8'h72, 8'h81, 8'h82};
      expect_tile(6'h2A, d, 4);
      start_tile(6'h2A, d);
      wait_idle("fresh");

      // Randomized tiles with random back-pressure
      ready_mode = 1;
      for (int t = 0; t < 25; t++) begin
         int b;
         b = $urandom_range(0, (1 << ADDR_W) - 1);
         for (int i = 0; i < 4; i++) d[i] = $urandom_range(0, 255);
         expect_tile(b, d, 4);
         start_tile(b, d);
         wait_idle("rand");
      end
      ready_mode = 0;
      repeat (3) @(negedge clk);
      check("done_count", dones_seen, dones_exp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
